// File: rtl/whack_frame_sequencer.sv
// whack_frame_sequencer: per frame, clears the screen and then draws each of
// the 3x3 holes through the GraphicsControl load-x / load-y / plot-box
// handshake. A watchdog aborts the frame if the controller stops answering.
module whack_frame_sequencer #(
  parameter int unsigned X0          = 16,
  parameter int unsigned Y0          = 12,
  parameter int unsigned XSTEP       = 24,
  parameter int unsigned YSTEP       = 18,
  parameter logic [2:0]  MOLE_COLOUR = 3'b100,
  parameter logic [2:0]  HIT_COLOUR  = 3'b010,
  parameter logic [2:0]  HOLE_COLOUR = 3'b001,
  parameter bit          DRAW_EMPTY  = 1'b1,
  parameter int unsigned TIMEOUT     = 20000
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iStart,
  input  logic [8:0] iMoleMask,
  input  logic [8:0] iHitMask,
  input  logic       iDone,
  output logic       oLoadX,
  output logic       oPlotBox,
  output logic       oBlack,
  output logic [6:0] oXY_Coord,
  output logic [2:0] oColour,
  output logic       oBusy,
  output logic       oFrameDone,
  output logic       oError
);

  localparam int unsigned NHOLES = 9;
  localparam int unsigned HW     = 4;
  localparam int unsigned WDW    = 15;
  localparam int unsigned CW     = 7;
  localparam int unsigned COLW   = 3;

  localparam logic [HW-1:0]  LAST_HOLE = HW'(NHOLES - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_CWAIT,
    S_SEL,
    S_ARM,
    S_GAP,
    S_XLD,
    S_XHOLD,
    S_YSET,
    S_DRAW,
    S_DWAIT,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hole_q, hole_d;
  logic [8:0]      mole_q, hit_q;
  logic [WDW-1:0]  wd_q;
  logic            seen_low_q;

  logic            accept_c;
  logic            timeout_c;
  logic            done_edge_c;
  logic            wd_hit_c;
  logic            skip_c;
  logic [COLW-1:0] hole_colour_c;
  logic [CW-1:0]   hole_x_c;
  logic [CW-1:0]   hole_y_c;

  logic            load_x_d, plot_box_d, black_d, busy_d, frame_done_d, error_d;
  logic [CW-1:0]   xy_d;
  logic [COLW-1:0] colour_d;

  // Box origin x for a hole index (column = index mod 3).
  function automatic logic [CW-1:0] hole_x(input logic [HW-1:0] h);
    int unsigned col;
    col = 32'(h) % 32'd3;
    return CW'(X0 + col * XSTEP);
  endfunction

  // Box origin y for a hole index (row = index div 3).
  function automatic logic [CW-1:0] hole_y(input logic [HW-1:0] h);
    int unsigned row;
    row = 32'(h) / 32'd3;
    return CW'(Y0 + row * YSTEP);
  endfunction

  // Per-hole decode: geometry, colour priority and the empty-hole skip.
  always_comb begin
    hole_x_c      = hole_x(hole_q);
    hole_y_c      = hole_y(hole_q);
    hole_colour_c = HOLE_COLOUR;
    if (hit_q[hole_q]) begin
      hole_colour_c = HIT_COLOUR;
    end else if (mole_q[hole_q]) begin
      hole_colour_c = MOLE_COLOUR;
    end
    skip_c      = !DRAW_EMPTY && !mole_q[hole_q] && !hit_q[hole_q];
    done_edge_c = seen_low_q && iDone;
    wd_hit_c    = (wd_q == WD_LIMIT);
  end

  // State register.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; only a real 0->1 done edge or the watchdog leaves a wait.
  always_comb begin
    state_d   = state_q;
    hole_d    = hole_q;
    accept_c  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          accept_c = 1'b1;
          hole_d   = '0;
          state_d  = S_CLR;
        end
      end
      S_CLR:   state_d = S_CWAIT;
      S_CWAIT: begin
        if (done_edge_c) begin
          hole_d  = '0;
          state_d = S_SEL;
        end else if (wd_hit_c) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_SEL: begin
        if (skip_c) begin
          if (hole_q == LAST_HOLE) begin
            state_d = S_FIN;
          end else begin
            hole_d = hole_q + HW'(1);
          end
        end else begin
          state_d = S_ARM;
        end
      end
      S_ARM:   state_d = S_GAP;
      S_GAP:   state_d = S_XLD;
      S_XLD:   state_d = S_XHOLD;
      S_XHOLD: state_d = S_YSET;
      S_YSET:  state_d = S_DRAW;
      S_DRAW:  state_d = S_DWAIT;
      S_DWAIT: begin
        if (done_edge_c) begin
          if (hole_q == LAST_HOLE) begin
            state_d = S_FIN;
          end else begin
            hole_d  = hole_q + HW'(1);
            state_d = S_SEL;
          end
        end else if (wd_hit_c) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the state being entered, so every output is registered.
  always_comb begin
    load_x_d     = 1'b0;
    plot_box_d   = 1'b0;
    black_d      = 1'b0;
    frame_done_d = 1'b0;
    xy_d         = '0;
    colour_d     = '0;
    busy_d       = (state_d != S_IDLE) && (state_d != S_FIN);
    error_d      = oError;
    if (accept_c) begin
      error_d = 1'b0;
    end
    if (timeout_c) begin
      error_d = 1'b1;
    end
    case (state_d)
      S_CLR:   black_d = 1'b1;
      S_ARM:   load_x_d = 1'b1;
      S_XLD: begin
        load_x_d = 1'b1;
        xy_d     = hole_x_c;
      end
      S_XHOLD: xy_d = hole_x_c;
      S_YSET, S_DWAIT: begin
        xy_d     = hole_y_c;
        colour_d = hole_colour_c;
      end
      S_DRAW: begin
        plot_box_d = 1'b1;
        xy_d       = hole_y_c;
        colour_d   = hole_colour_c;
      end
      S_FIN:   frame_done_d = 1'b1;
      default: ;
    endcase
  end

  // Hole index and masks latched at an accepted start.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      hole_q <= '0;
      mole_q <= '0;
      hit_q  <= '0;
    end else begin
      hole_q <= hole_d;
      if (accept_c) begin
        mole_q <= iMoleMask;
        hit_q  <= iHitMask;
      end
    end
  end

  // Watchdog and seen-low tracking; both restart whenever a wait is entered.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      wd_q       <= '0;
      seen_low_q <= 1'b0;
    end else if (state_q != S_CWAIT && state_q != S_DWAIT) begin
      wd_q       <= '0;
      seen_low_q <= 1'b0;
    end else begin
      wd_q <= wd_q + WDW'(1);
      if (!iDone) begin
        seen_low_q <= 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oLoadX     <= 1'b0;
      oPlotBox   <= 1'b0;
      oBlack     <= 1'b0;
      oXY_Coord  <= '0;
      oColour    <= '0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
      oError     <= 1'b0;
    end else begin
      oLoadX     <= load_x_d;
      oPlotBox   <= plot_box_d;
      oBlack     <= black_d;
      oXY_Coord  <= xy_d;
      oColour    <= colour_d;
      oBusy      <= busy_d;
      oFrameDone <= frame_done_d;
      oError     <= error_d;
    end
  end

endmodule

// File: tb/tb_whack_frame_sequencer.sv
// tb_whack_frame_sequencer: two sequencer instances (draw-all with a short
// watchdog, and skip-empty) driven by a per-cycle controller responder and
// compared against a hole-list model of the frame.
module tb_whack_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [1:0] start;
  logic [1:0] done;
  logic [8:0] mole [2];
  logic [8:0] hit  [2];

  logic [1:0] load_x, plot_box, black, busy, frame_done, error;
  logic [6:0] xy     [2];
  logic [2:0] colour [2];

  int n_checks = 0;
  int n_fail   = 0;

  whack_frame_sequencer #(.DRAW_EMPTY(1'b1), .TIMEOUT(50)) u_all (
    .iClock(clk), .iResetn(resetn), .iStart(start[0]),
    .iMoleMask(mole[0]), .iHitMask(hit[0]), .iDone(done[0]),
    .oLoadX(load_x[0]), .oPlotBox(plot_box[0]), .oBlack(black[0]),
    .oXY_Coord(xy[0]), .oColour(colour[0]), .oBusy(busy[0]),
    .oFrameDone(frame_done[0]), .oError(error[0])
  );

  whack_frame_sequencer #(.DRAW_EMPTY(1'b0)) u_skip (
    .iClock(clk), .iResetn(resetn), .iStart(start[1]),
    .iMoleMask(mole[1]), .iHitMask(hit[1]), .iDone(done[1]),
    .oLoadX(load_x[1]), .oPlotBox(plot_box[1]), .oBlack(black[1]),
    .oXY_Coord(xy[1]), .oColour(colour[1]), .oBusy(busy[1]),
    .oFrameDone(frame_done[1]), .oError(error[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] outs(input int sel);
    return {load_x[sel], plot_box[sel], black[sel], xy[sel], colour[sel],
            busy[sel], frame_done[sel], error[sel]};
  endfunction

  function automatic int model_colour(input logic m, input logic h);
    if (h) return 2;
    if (m) return 4;
    return 1;
  endfunction

  // One frame on instance sel. dly: strobe-to-done-rise delay (>=2).
  // stale: keep done high across the clear, pulse it low 10 cycles later.
  // mid_start: plot count after which a stray start is pulsed (-1 none).
  // abort_after: plot count after which reset is asserted (-1 none).
  task automatic run_frame(input int sel, input logic [8:0] m, input logic [8:0] h,
                           input int dly, input bit stale, input int mid_start,
                           input int abort_after);
    int exp_i[$], exp_x[$], exp_y[$], exp_c[$];
    int nblack, nplot, nfd, overlap, early, cnt, stale_cnt;
    int last_plot_cyc, fd_cyc;
    logic [6:0] last_x;
    bit edge_given, finished, abort_pending;
    nblack = 0; nplot = 0; nfd = 0; overlap = 0; early = 0; cnt = 0; stale_cnt = 0;
    last_plot_cyc = 0; fd_cyc = 0; last_x = '0;
    edge_given = !stale; finished = 1'b0; abort_pending = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (sel == 0 || m[i] || h[i]) begin
        exp_i.push_back(i);
        exp_x.push_back(16 + (i % 3) * 24);
        exp_y.push_back(12 + (i / 3) * 18);
        exp_c.push_back(model_colour(m[i], h[i]));
      end
    end
    @(negedge clk);
    mole[sel] = m; hit[sel] = h; start[sel] = 1'b1; done[sel] = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start[sel] = 1'b0;
      mole[sel] = 9'($urandom); hit[sel] = 9'($urandom);
      if (abort_pending) begin
        check_val("abort_busy", 32'(busy[sel]), 1);
        #2 resetn = 1'b0;
        #1 check_val("async_reset_outs", 32'(outs(sel)), 0);
        return;
      end
      if (cyc == 0) begin
        check_val("start_busy", 32'(busy[sel]), 1);
        check_val("start_black", 32'(black[sel]), 1);
        check_val("start_error_clear", 32'(error[sel]), 0);
      end
      if (cyc == 1) check_val("black_one_cycle", 32'(black[sel]), 0);
      if (32'(load_x[sel]) + 32'(plot_box[sel]) + 32'(black[sel]) > 1) overlap++;
      if (black[sel]) nblack++;
      if (load_x[sel]) begin
        last_x = xy[sel];
        if (!edge_given) early++;
      end
      if (plot_box[sel]) begin
        if (nplot < exp_x.size()) begin
          check_val("hole_x", 32'(last_x), exp_x[nplot]);
          check_val("hole_y", 32'(xy[sel]), exp_y[nplot]);
          check_val("hole_colour", 32'(colour[sel]), exp_c[nplot]);
        end
        nplot++;
        last_plot_cyc = cyc;
        if (nplot == mid_start) begin
          start[sel] = 1'b1; mole[sel] = ~m; hit[sel] = ~h;
        end
        if (nplot == abort_after) abort_pending = 1'b1;
      end
      if (frame_done[sel]) begin
        nfd++;
        fd_cyc = cyc;
        check_val("fin_busy_low", 32'(busy[sel]), 0);
        finished = 1'b1;
      end
      if (black[sel] && stale) begin
        stale_cnt = 10;
      end else if (black[sel] || plot_box[sel]) begin
        done[sel] = 1'b0; cnt = dly;
      end else if (stale_cnt > 0) begin
        stale_cnt--;
        if (stale_cnt == 0) begin
          done[sel] = 1'b0; edge_given = 1'b1; cnt = 1;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) done[sel] = 1'b1;
      end
      if (finished) break;
    end
    check_val("frame_completed", 32'(finished), 1);
    check_val("black_pulses", nblack, 1);
    check_val("plot_pulses", nplot, exp_x.size());
    check_val("frame_done_pulses", nfd, 1);
    check_val("strobe_overlap", overlap, 0);
    check_val("stale_done_advance", early, 0);
    if (finished && exp_i.size() > 0)
      check_val("fin_latency", fd_cyc - last_plot_cyc, dly + 1 + (8 - exp_i[exp_i.size() - 1]));
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (frame_done[sel] || black[sel] || busy[sel]) cnt++;
    end
    check_val("idle_after_frame", cnt, 0);
  endtask

  // Controller never answers: watchdog must fire after TIMEOUT cycles of CWAIT.
  task automatic run_watchdog();
    int busy_cnt, fd;
    bit got_err;
    busy_cnt = 0; fd = 0; got_err = 1'b0;
    @(negedge clk);
    mole[0] = 9'($urandom); hit[0] = 9'($urandom); start[0] = 1'b1; done[0] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (frame_done[0]) fd++;
      if (error[0]) begin
        got_err = 1'b1;
        check_val("wd_busy_low", 32'(busy[0]), 0);
        break;
      end
      if (busy[0]) busy_cnt++;
    end
    check_val("wd_error_set", 32'(got_err), 1);
    check_val("wd_busy_cycles", busy_cnt, 51);
    check_val("wd_no_frame_done", fd, 0);
    repeat (3) @(negedge clk);
    check_val("wd_error_sticky", 32'(error[0]), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation still running at %0t, expected finish", $time);
    $fatal(1, "time limit");
  end

  initial begin
    resetn = 1'b0; start = '0; done = 2'b11;
    mole[0] = '0; mole[1] = '0; hit[0] = '0; hit[1] = '0;
    // Reset held with random inputs.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 2'($urandom); done = 2'($urandom);
      mole[0] = 9'($urandom); hit[0] = 9'($urandom);
      mole[1] = 9'($urandom); hit[1] = 9'($urandom);
      #1;
      check_val("reset_outs_all", 32'(outs(0)), 0);
      check_val("reset_outs_skip", 32'(outs(1)), 0);
    end
    @(negedge clk);
    start = '0; done = 2'b11; resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("post_reset_all", 32'(outs(0)), 0);
      check_val("post_reset_skip", 32'(outs(1)), 0);
    end

    run_frame(0, 9'h005, 9'h004, 4, 1'b0, -1, -1);
    run_frame(1, 9'h100, 9'h000, 4, 1'b0, -1, -1);
    run_frame(0, 9'($urandom), 9'($urandom), 3, 1'b1, -1, -1);

    run_watchdog();
    run_frame(0, 9'($urandom), 9'($urandom), 2, 1'b0, -1, -1);

    // Stray start mid-frame, then reset while hole 4 waits for done.
    run_frame(0, 9'($urandom), 9'($urandom), 3, 1'b0, 2, 5);
    @(negedge clk);
    check_val("abort_held_outs", 32'(outs(0)), 0);
    resetn = 1'b1; done[0] = 1'b1;
    @(negedge clk);
    check_val("abort_release_outs", 32'(outs(0)), 0);
    run_frame(0, 9'($urandom), 9'($urandom), 4, 1'b0, -1, -1);

    for (int r = 0; r < 8; r++) begin
      run_frame(int'($urandom_range(0, 1)), 9'($urandom), 9'($urandom & $urandom),
                int'($urandom_range(2, 6)), 1'b0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
